bcd_counter_n: RTL
==================

Name: bcd_counter_n

Overview:
- Parametrised N-digit BCD up/down counter, the successor of the fixed 4-digit cascade counter.
- Adds selectable count direction, synchronous clear, parallel load with BCD validation, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
- Sits between the board button/enable logic and the 7-segment display driver.
- Digits are exposed as one packed bus; the per-digit cascade enables are exposed for debug.

Parameters:
- NDIGITS, 4, number of BCD digits (legal range 1..8).
- WRAP, 1, 1 = wrap at the count limits; 0 = saturate (hold) at the count limits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  count enable; one count step per clk while high.
- up_dn  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load.
- load_data  in  4*NDIGITS  digits to load; digit i is in bits [4i+3:4i].
- q  out  4*NDIGITS  current count; digit 0 is the least significant.
- dig_ena  out  NDIGITS  combinational cascade enable of each digit.
- tc  out  1  registered terminal-count pulse.
- ovf  out  1  sticky overflow/underflow flag.
- load_err  out  1  registered 1-cycle pulse: a loaded digit was invalid.

Behaviour:
- Reset (rst low, asynchronous): q=0, tc=0, ovf=0, load_err=0. Release is synchronous to the next clk edge.
- Priority on each rising edge: clr > load > count. Lower-priority requests in the same cycle are ignored.
- clr: q=0, ovf=0, tc=0, load_err=0 on the next edge.
- load:
  - q=load_data on the next edge.
  - Any digit >9 is written as 9, and load_err=1 for exactly one cycle.
  - tc=0 and ovf is unchanged.
  - ena is ignored in a load cycle.
- Count latency: q updates on the clk edge where ena=1. There is no pipeline.
- dig_ena:
  - dig_ena[0]=ena.
  - Up: dig_ena[i]=dig_ena[i-1] & (digit i-1 == 9).
  - Down: dig_ena[i]=dig_ena[i-1] & (digit i-1 == 0).
  - dig_ena is forced to 0 while clr or load is high.
- Digit step:
  - Up: 0..8 increments; 9 goes to 0.
  - Down: 1..9 decrements; 0 goes to 9.
  - A digit steps only when its dig_ena is 1.
- Terminal event: up at all-9s, or down at all-0s, with ena=1 and no clr/load.
  - WRAP=1: q wraps (all-9s goes to 0, all-0s goes to all-9s).
  - WRAP=0: q holds its value.
  - In both modes, tc=1 on the following cycle and ovf is set.
- tc is a 1-cycle pulse per terminal event. At saturation with ena held high, tc re-pulses every cycle.
- up_dn may change on any cycle. Its value is sampled on the same edge as the count.
- A stored digit >9 is unreachable, because loads are sanitised.
- Reset mid-count dominates all other inputs immediately.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W=4
  - BCD_MAX=4'd9
  - BCD_MIN=4'd0
  - function bcd_sat(d), which returns min(d,9)
- Sub-module bcd_digit, instantiated NDIGITS times with a generate loop. Ports: clk, rst, ena_in, up_dn, clr, load, d_in, q, at_lim (digit == 9 when up, == 0 when down).
- The top level forms the dig_ena chain from the at_lim outputs, and detects the terminal event as the AND of all at_lim with ena.

Test Plan (NDIGITS=4 unless stated):
- Reset: pulse rst low mid-count at q=0x0347 -> q=0x0000, tc=0 and ovf=0 immediately, without waiting for a clk edge.
- Up cascade: load 0x0999, then ena=1, up_dn=1 for one cycle -> q=0x1000; during that cycle dig_ena=4'b1111.
- WRAP=1 up: load 0x9999, then one enabled up step -> q=0x0000; tc=1 for exactly one cycle; ovf=1 until clr.
- WRAP=0 down: load 0x0000, then three enabled down steps -> q stays 0x0000; tc pulses each cycle; ovf=1.
- Invalid load: load_data=0x3C5F -> q=0x3959, with a 1-cycle load_err pulse.
- Priority and direction: clr=1, load=1 and ena=1 in the same cycle -> q=0; then from 0x0010, one down step -> 0x0009.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and helpers for the N-digit counter.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  // Clamp a raw nibble into the legal BCD range.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit: up/down step with wrap, sync clear and sanitised load.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_in,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] d_in,
  output logic [BCD_W-1:0] q,
  output logic             at_lim
);

  assign at_lim = up_dn ? (q == BCD_MAX) : (q == BCD_MIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= bcd_sat(d_in);
    end else if (ena_in) begin
      if (up_dn) q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      else       q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with wrap/saturate, terminal-count pulse,
// sticky overflow and load validation.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 4,
  parameter bit          WRAP    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     up_dn,
  input  logic                     clr,
  input  logic                     load,
  input  logic [BCD_W*NDIGITS-1:0] load_data,
  output logic [BCD_W*NDIGITS-1:0] q,
  output logic [NDIGITS-1:0]       dig_ena,
  output logic                     tc,
  output logic                     ovf,
  output logic                     load_err
);

  logic [NDIGITS-1:0] at_lim;
  logic [NDIGITS-1:0] step_ena;
  logic               term_evt;
  logic               load_bad;

  always_comb begin
    dig_ena    = '0;
    dig_ena[0] = ena & ~clr & ~load;
    for (int unsigned i = 1; i < NDIGITS; i++) begin
      dig_ena[i] = dig_ena[i-1] & at_lim[i-1];
    end
  end

  // The top of the chain already folds in ena and the clr/load gating.
  assign term_evt = dig_ena[NDIGITS-1] & at_lim[NDIGITS-1];

  // Saturating mode: suppress every digit step on a terminal event so q holds.
  assign step_ena = (term_evt && (WRAP == 1'b0)) ? '0 : dig_ena;

  always_comb begin
    load_bad = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (load_data[BCD_W*i +: BCD_W] > BCD_MAX) load_bad = 1'b1;
    end
  end

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .ena_in (step_ena[g]),
      .up_dn  (up_dn),
      .clr    (clr),
      .load   (load),
      .d_in   (load_data[BCD_W*g +: BCD_W]),
      .q      (q[BCD_W*g +: BCD_W]),
      .at_lim (at_lim[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc       <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (clr) begin
      tc       <= 1'b0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      tc       <= 1'b0;
      load_err <= load_bad;
    end else begin
      tc       <= term_evt;
      load_err <= 1'b0;
      if (term_evt) ovf <= 1'b1;
    end
  end

endmodule
